// File: rtl/change_dispenser_pkg.sv
// Shared definitions for the change dispenser: FSM state codes, product
// type codes and the layout of one queued sale.
package change_dispenser_pkg;

  // FSM state encoding
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_REL   = 3'd1;
  localparam logic [2:0] ST_REQ   = 3'd2;
  localparam logic [2:0] ST_GAP   = 3'd3;
  localparam logic [2:0] ST_FAULT = 3'd4;

  // Product type carried with each queued sale
  localparam logic TYPE_P1 = 1'b0;
  localparam logic TYPE_P2 = 1'b1;

  // Default width of the change field
  localparam int unsigned CHG_W_DEFAULT = 2;

  // One queued sale at the default width. The top packs its queue words in
  // the same order ({type, change}) for any CHG_W.
  typedef struct packed {
    logic                     typ;
    logic [CHG_W_DEFAULT-1:0] change;
  } sale_entry_t;

endpackage

// File: rtl/chg_fifo.sv
// Synchronous FIFO of packed sale entries. A push while full is accepted
// only when a pop happens in the same cycle; otherwise it is ignored and the
// caller is expected to flag the loss.
module chg_fifo #(
  parameter int unsigned WIDTH = 3,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  // A pop frees the slot the push needs, so full alone does not block it
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rptr];

  // Storage array, no reset needed since count gates every read
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wptr] <= wdata;
    end
  end

  // Pointers and occupancy count
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        wptr <= wptr + AW'(1);
      end
      if (do_pop) begin
        rptr <= rptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/change_dispenser.sv
// Change dispenser: queues sales from the vending controller, pulses the
// product release, then pays change one coin at a time over a req/ack
// handshake with timeout. Optional macro CHANGE_LOG_EN adds a saturating
// count of dispensed coins on output coins_total.
module change_dispenser
  import change_dispenser_pkg::*;
#(
  parameter int unsigned CHG_W       = CHG_W_DEFAULT,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned ACK_TIMEOUT = 15,
  parameter int unsigned GAP_CYC     = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             vend1,
  input  logic             vend2,
  input  logic [CHG_W-1:0] change_in,
  input  logic             coin_ack,
  input  logic             fault_clr,
  output logic             coin_req,
  output logic             prod1_rel,
  output logic             prod2_rel,
  output logic             busy,
  output logic             full,
  output logic             fault,
`ifdef CHANGE_LOG_EN
  output logic [15:0]      coins_total,
`endif
  output logic             ovf
);

  localparam int unsigned EW = CHG_W + 1;
  localparam int unsigned TW = $clog2(ACK_TIMEOUT + 1);
  localparam int unsigned GW = (GAP_CYC > 1) ? $clog2(GAP_CYC + 1) : 1;

  // Edge detect
  logic vend1_q;
  logic vend2_q;
  logic rise1;
  logic rise2;
  logic push;
  logic both_rise;

  // Queue interface
  logic [EW-1:0] wdata;
  logic [EW-1:0] head;
  logic          empty;
  logic          pop;

  // FSM and working registers
  logic [2:0]       state_q, state_d;
  logic             typ_q, typ_d;
  logic [CHG_W-1:0] rem_q, rem_d;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic             ovf_q;

  assign rise1     = vend1 & ~vend1_q;
  assign rise2     = vend2 & ~vend2_q;
  assign both_rise = rise1 & rise2;
  assign push      = rise1 ^ rise2;
  assign wdata     = {(rise2 ? TYPE_P2 : TYPE_P1), change_in};
  assign pop       = (state_q == ST_IDLE) & ~empty;

  chg_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (wdata),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  // Previous vend levels for rising-edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      vend1_q <= 1'b0;
      vend2_q <= 1'b0;
    end else begin
      vend1_q <= vend1;
      vend2_q <= vend2;
    end
  end

  // Sticky overflow: simultaneous sales, or a push that the queue cannot take
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (both_rise || (push && full && !pop)) begin
      ovf_q <= 1'b1;
    end
  end

  // Next-state logic for the release / payout sequencer
  always_comb begin
    state_d = state_q;
    typ_d   = typ_q;
    rem_d   = rem_q;
    tmo_d   = tmo_q;
    gap_d   = gap_q;
    unique case (state_q)
      ST_IDLE: begin
        if (!empty) begin
          typ_d   = head[CHG_W];
          rem_d   = head[CHG_W-1:0];
          state_d = ST_REL;
        end
      end
      ST_REL: begin
        tmo_d   = '0;
        gap_d   = '0;
        state_d = (rem_q == '0) ? ST_GAP : ST_REQ;
      end
      ST_REQ: begin
        // An ack arriving on the final timeout cycle still counts
        if (coin_ack) begin
          rem_d   = rem_q - CHG_W'(1);
          tmo_d   = '0;
          gap_d   = '0;
          state_d = ST_GAP;
        end else if (tmo_q == TW'(ACK_TIMEOUT - 1)) begin
          tmo_d   = '0;
          state_d = ST_FAULT;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      ST_GAP: begin
        if (gap_q == GW'(GAP_CYC - 1)) begin
          gap_d   = '0;
          tmo_d   = '0;
          state_d = (rem_q != '0) ? ST_REQ : ST_IDLE;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      ST_FAULT: begin
        // Clearing the fault abandons whatever change was still owed
        if (fault_clr) begin
          rem_d   = '0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Sequencer state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      typ_q   <= TYPE_P1;
      rem_q   <= '0;
      tmo_q   <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      typ_q   <= typ_d;
      rem_q   <= rem_d;
      tmo_q   <= tmo_d;
      gap_q   <= gap_d;
    end
  end

`ifdef CHANGE_LOG_EN
  logic coin_taken;
  assign coin_taken = (state_q == ST_REQ) & coin_ack;

  // Saturating count of coins the hopper acknowledged
  always_ff @(posedge clk) begin
    if (rst) begin
      coins_total <= '0;
    end else if (coin_taken && (coins_total != 16'hFFFF)) begin
      coins_total <= coins_total + 16'd1;
    end
  end
`endif

  // Outputs decoded from registered state only
  always_comb begin
    coin_req  = (state_q == ST_REQ);
    prod1_rel = (state_q == ST_REL) && (typ_q == TYPE_P1);
    prod2_rel = (state_q == ST_REL) && (typ_q == TYPE_P2);
    fault     = (state_q == ST_FAULT);
    busy      = (state_q != ST_IDLE) || !empty;
    ovf       = ovf_q;
  end

endmodule
